// File: rtl/alu_cmd_master.sv
// alu_cmd_master: buffers host commands in a FIFO, issues them in order to the
// ALU through a registered wdata/wvalid stage with an outstanding-command limit,
// and returns ALU results to the host through a one-entry result register.
// A flush drops queued commands, lets the staged command finish, then waits
// for all in-flight results before pulsing flush_done.
module alu_cmd_master #(
    parameter int DATA_W    = 10,
    parameter int CMD_DEPTH = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              cmd_data,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    output logic [DATA_W-1:0]              res_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [DATA_W-1:0]              wdata,
    output logic                           wvalid,
    input  logic                           wready,
    input  logic                           rvalid,
    input  logic [DATA_W-1:0]              rdata,
    output logic                           rready,
    input  logic                           flush,
    output logic                           flush_done,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst,
    output logic                           err_unexp
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH_W, ST_FLUSH_R} state_t;

    state_t                           state_q, state_d;
    logic                             started_q, started_d;
    logic [CMD_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [AW-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                    rd_ptr_q, rd_ptr_d;
    logic [AW:0]                      cnt_q, cnt_d;
    logic                             wvalid_q, wvalid_d;
    logic [DATA_W-1:0]                wdata_q, wdata_d;
    logic                             res_valid_q, res_valid_d;
    logic [DATA_W-1:0]                res_data_q, res_data_d;
    logic [OW-1:0]                    outst_q, outst_d;
    logic                             err_q, err_d;

    logic          in_run, flush_now, fifo_full, fifo_empty;
    logic          push, load, w_xfer, r_xfer, r_take;
    logic [OW:0]   outst_wr;

    // Handshake qualifiers. started_q keeps cmd_ready/rready low while in
    // reset and for the edge that releases it.
    always_comb begin
        in_run     = (state_q == ST_RUN);
        flush_now  = flush && in_run;
        fifo_full  = (cnt_q == (AW+1)'(CMD_DEPTH));
        fifo_empty = (cnt_q == '0);
        cmd_ready  = started_q && !fifo_full && in_run;
        push       = cmd_valid && cmd_ready && !flush_now;
        w_xfer     = wvalid_q && wready;
        rready     = started_q && (!res_valid_q || res_ready);
        r_xfer     = rvalid && rready;
        r_take     = r_xfer && (outst_q != '0);
        // Only this edge's write transfer counts toward the limit, so a
        // returning result frees a slot one edge later.
        outst_wr   = {1'b0, outst_q} + (OW+1)'(w_xfer);
        load       = (!wvalid_q || w_xfer) && !fifo_empty && in_run && !flush_now &&
                     (outst_wr < (OW+1)'(MAX_OUTST));
    end

    // Command FIFO: a flush in RUN empties it and blocks that edge's push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_now) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = cmd_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (load) rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(load);
        end
    end

    // Issue stage, outstanding counter, result register and sticky error.
    always_comb begin
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        outst_d     = outst_q;
        err_d       = err_q | (r_xfer && (outst_q == '0));
        started_d   = 1'b1;
        if (load) begin
            wvalid_d = 1'b1;
            wdata_d  = mem_q[rd_ptr_q];
        end else if (w_xfer) begin
            wvalid_d = 1'b0;
        end
        case ({w_xfer, r_take})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
        if (r_take) begin
            res_valid_d = 1'b1;
            res_data_d  = rdata;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Flush sequencing: drop queue, finish staged write, drain results.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_RUN:     if (flush) state_d = ST_FLUSH_W;
            ST_FLUSH_W: if (!wvalid_q) state_d = ST_FLUSH_R;
            ST_FLUSH_R: if (outst_q == '0) begin
                flush_done = 1'b1;
                state_d    = ST_RUN;
            end
            default:    state_d = ST_RUN;
        endcase
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            started_q   <= 1'b0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
        end
    end

    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign outst     = outst_q;
    assign err_unexp = err_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Testbench for alu_cmd_master: directed scenarios with random data plus a
// random-traffic run checked against queue-based host/ALU models.
module tb_alu_cmd_master;

    localparam int DW    = 10;
    localparam int DEPTH = 4;
    localparam int MAXO  = 8;
    localparam int OW    = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready = 1'b0;
    logic          rvalid = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rready;
    logic          flush = 1'b0;
    logic          flush_done;
    logic [OW-1:0] outst;
    logic          err_unexp;

    int n_cmp = 0;
    int n_err = 0;

    alu_cmd_master #(.DATA_W(DW), .CMD_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .reset(reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready),
        .flush(flush), .flush_done(flush_done),
        .outst(outst), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ALU model: a result is a fixed function of its command.
    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] c);
        return c ^ 10'h2B7;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 1'b0; wready = 1'b0; rvalid = 1'b0; res_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, res_valid, wvalid, rready, flush_done, err_unexp} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b need 000000",
                     {cmd_ready, res_valid, wvalid, rready, flush_done, err_unexp});
        end
        n_cmp++;
        if (outst !== '0) begin n_err++; $display("FAIL reset_outst: got %0d need 0", outst); end
        n_cmp++;
        if ({wdata, res_data} !== '0) begin
            n_err++; $display("FAIL reset_data: wdata=%h res_data=%h need 0", wdata, res_data);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_early: got %b need 0", cmd_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_rise: got %b need 1", cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        cmd_data = 10'h1A5; cmd_valid = 1'b1; wready = 1'b0;
        step();
        cmd_valid = 1'b0;
        #1;
        n_cmp++;
        if (wvalid !== 1'b0) begin n_err++; $display("FAIL basic_lat_early: wvalid=%b need 0", wvalid); end
        @(posedge clk); #1;
        n_cmp++;
        if (wvalid !== 1'b1 || wdata !== 10'h1A5) begin
            n_err++; $display("FAIL basic_issue: wvalid=%b wdata=%h need 1/1a5", wvalid, wdata);
        end
        @(negedge clk);
        wready = 1'b1;
        step();
        wready = 1'b0;
        #1;
        n_cmp++;
        if (outst !== OW'(1) || wvalid !== 1'b0) begin
            n_err++; $display("FAIL basic_outst1: outst=%0d wvalid=%b need 1/0", outst, wvalid);
        end
        rvalid = 1'b1; rdata = 10'h0F0; res_ready = 1'b0;
        #1;
        n_cmp++;
        if (rready !== 1'b1) begin n_err++; $display("FAIL basic_rready: got %b need 1", rready); end
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 10'h0F0 || outst !== '0) begin
            n_err++; $display("FAIL basic_result: res_valid=%b res_data=%h outst=%0d need 1/0f0/0",
                              res_valid, res_data, outst);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        #1;
        n_cmp++;
        if (res_valid !== 1'b0) begin n_err++; $display("FAIL basic_res_taken: res_valid=%b need 0", res_valid); end
    endtask

    task automatic test_max_outst();
        logic [DW-1:0] c [12];
        int np = 0;
        int nw = 0;
        for (int i = 0; i < 12; i++) c[i] = DW'($urandom);
        do_reset();
        wready = 1'b1; res_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            cmd_valid = (np < 12);
            cmd_data  = c[np % 12];
            #1;
            if (wvalid && wready) begin
                n_cmp++;
                if (nw >= 12 || wdata !== c[nw % 12]) begin
                    n_err++; $display("FAIL max_order: write %0d wdata=%h need %h", nw, wdata, c[nw % 12]);
                end
                nw++;
            end
            if (cmd_valid && cmd_ready) np++;
            step();
        end
        cmd_valid = 1'b0;
        #1;
        n_cmp++;
        if (nw !== 8 || outst !== OW'(MAXO) || wvalid !== 1'b0 || np !== 12) begin
            n_err++; $display("FAIL max_limit: writes=%0d outst=%0d wvalid=%b pushed=%0d need 8/8/0/12",
                              nw, outst, wvalid, np);
        end
        wready = 1'b0;
        rvalid = 1'b1; rdata = alu_f(c[0]);
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if (wvalid !== 1'b0 || outst !== OW'(MAXO - 1)) begin
            n_err++; $display("FAIL max_release_edge: wvalid=%b outst=%0d need 0/7", wvalid, outst);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (wvalid !== 1'b1 || wdata !== c[8]) begin
            n_err++; $display("FAIL max_ninth: wvalid=%b wdata=%h need 1/%h", wvalid, wdata, c[8]);
        end
        @(negedge clk);
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] c [8];
        int np = 0;
        int nw = 0;
        for (int i = 0; i < 8; i++) c[i] = DW'($urandom);
        do_reset();
        wready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_valid = 1'b1;
            cmd_data  = c[np % 8];
            #1;
            if (wvalid) begin
                n_cmp++;
                if (wdata !== c[0]) begin n_err++; $display("FAIL full_hold: wdata=%h need %h", wdata, c[0]); end
            end
            if (cmd_ready) np++;
            step();
        end
        cmd_valid = 1'b0;
        #1;
        // One command sits in the issue stage, DEPTH more fill the FIFO.
        n_cmp++;
        if (np !== DEPTH + 1 || cmd_ready !== 1'b0 || wvalid !== 1'b1) begin
            n_err++; $display("FAIL full_stop: accepted=%0d cmd_ready=%b wvalid=%b need %0d/0/1",
                              np, cmd_ready, wvalid, DEPTH + 1);
        end
        wready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (wvalid && wready) begin
                n_cmp++;
                if (wdata !== c[nw % 8]) begin n_err++; $display("FAIL full_drain: wdata=%h need %h", wdata, c[nw % 8]); end
                nw++;
            end
            step();
        end
        wready = 1'b0;
        n_cmp++;
        if (nw !== DEPTH + 1) begin n_err++; $display("FAIL full_count: writes=%0d need %0d", nw, DEPTH + 1); end
    endtask

    task automatic test_res_backpressure();
        logic [DW-1:0] c [3];
        int np = 0;
        int ri = 0;
        int h = 0;
        for (int i = 0; i < 3; i++) c[i] = DW'($urandom);
        do_reset();
        wready = 1'b1; res_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            cmd_valid = (np < 3);
            cmd_data  = c[np % 3];
            #1;
            if (cmd_valid && cmd_ready) np++;
            step();
        end
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            rvalid = (ri < 3);
            rdata  = alu_f(c[ri % 3]);
            #1;
            if (rvalid && rready) ri++;
            step();
        end
        #1;
        n_cmp++;
        if (ri !== 1 || rready !== 1'b0 || res_valid !== 1'b1 || res_data !== alu_f(c[0])) begin
            n_err++; $display("FAIL bp_hold: taken=%0d rready=%b res_valid=%b res_data=%h need 1/0/1/%h",
                              ri, rready, res_valid, res_data, alu_f(c[0]));
        end
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            rvalid = (ri < 3);
            rdata  = alu_f(c[ri % 3]);
            #1;
            if (res_valid && res_ready) begin
                n_cmp++;
                if (res_data !== alu_f(c[h % 3])) begin
                    n_err++; $display("FAIL bp_order: res_data=%h need %h", res_data, alu_f(c[h % 3]));
                end
                h++;
            end
            if (rvalid && rready) ri++;
            step();
        end
        rvalid = 1'b0; res_ready = 1'b0;
        n_cmp++;
        if (h !== 3) begin n_err++; $display("FAIL bp_rate: delivered=%0d in 3 cycles need 3", h); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] c [6];
        logic [DW-1:0] seen[$];
        logic [DW-1:0] pend[$];
        int np = 0;
        int h = 0;
        int fd = 0;
        bit done = 0;
        for (int i = 0; i < 6; i++) c[i] = DW'($urandom);
        do_reset();
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            cmd_valid = (np < 5);
            cmd_data  = c[np % 6];
            wready    = (seen.size() < 2);
            #1;
            if (wvalid && wready) begin seen.push_back(wdata); pend.push_back(wdata); end
            if (cmd_valid && cmd_ready) np++;
            step();
        end
        cmd_valid = 1'b0; wready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            rvalid = (pend.size() > 0);
            rdata  = (pend.size() > 0) ? alu_f(pend[0]) : '0;
            #1;
            if (!done) begin
                n_cmp++;
                if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL flush_cmd_ready: got %b need 0", cmd_ready); end
            end
            if (flush_done) begin
                fd++; done = 1;
                n_cmp++;
                if (outst !== '0) begin n_err++; $display("FAIL flush_done_outst: outst=%0d need 0", outst); end
            end
            if (wvalid && wready) begin seen.push_back(wdata); pend.push_back(wdata); end
            if (res_valid && res_ready) begin
                n_cmp++;
                if (res_data !== alu_f(c[h % 6])) begin
                    n_err++; $display("FAIL flush_res_order: res_data=%h need %h", res_data, alu_f(c[h % 6]));
                end
                h++;
            end
            if (rvalid && rready) void'(pend.pop_front());
            step();
        end
        rvalid = 1'b0;
        n_cmp++;
        if (seen.size() !== 3 || fd !== 1 || h !== 3 || np !== 5) begin
            n_err++; $display("FAIL flush_counts: writes=%0d flush_done=%0d results=%0d pushed=%0d need 3/1/3/5",
                              seen.size(), fd, h, np);
        end
        for (int i = 0; i < seen.size(); i++) begin
            n_cmp++;
            if (i >= 3 || seen[i] !== c[i]) begin
                n_err++; $display("FAIL flush_dropped: write %0d wdata=%h need %h", i, seen[i], c[i % 6]);
            end
        end
        cmd_valid = 1'b1; cmd_data = c[5];
        begin
            bit got = 0;
            for (int cyc = 0; cyc < 6 && !got; cyc++) begin
                #1;
                if (cmd_valid && cmd_ready) begin step(); cmd_valid = 1'b0; end
                else if (wvalid && wready) begin
                    got = 1;
                    n_cmp++;
                    if (wdata !== c[5]) begin n_err++; $display("FAIL flush_resume: wdata=%h need %h", wdata, c[5]); end
                    step();
                end else step();
            end
            cmd_valid = 1'b0;
            if (!got) begin
                n_cmp++; n_err++; $display("FAIL flush_resume: no write after flush, need %h", c[5]);
            end
        end
        wready = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_unexp();
        do_reset();
        rvalid = 1'b1; rdata = DW'($urandom);
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if (err_unexp !== 1'b1 || res_valid !== 1'b0 || outst !== '0) begin
            n_err++; $display("FAIL unexp_set: err=%b res_valid=%b outst=%0d need 1/0/0", err_unexp, res_valid, outst);
        end
        repeat (3) step();
        n_cmp++;
        if (err_unexp !== 1'b1) begin n_err++; $display("FAIL unexp_sticky: err=%b need 1", err_unexp); end
        cmd_valid = 1'b1; cmd_data = DW'($urandom); wready = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (wvalid !== 1'b1) begin n_err++; $display("FAIL unexp_burst: wvalid=%b need 1", wvalid); end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, wvalid, rready, res_valid, flush_done, err_unexp} !== 6'b0 || outst !== '0 ||
            wdata !== '0 || res_data !== '0) begin
            n_err++; $display("FAIL async_reset: flags=%b outst=%0d wdata=%h res_data=%h need all 0",
                              {cmd_ready, wvalid, rready, res_valid, flush_done, err_unexp}, outst, wdata, res_data);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [DW-1:0] host_q[$];
        logic [DW-1:0] pend[$];
        logic [DW-1:0] res_exp[$];
        int o_model = 0;
        bit rv_hold = 0;
        bit drain;
        do_reset();
        for (int cyc = 0; cyc < 560; cyc++) begin
            drain     = (cyc >= 500);
            cmd_valid = !drain && ($urandom_range(0, 3) != 0);
            cmd_data  = DW'($urandom);
            wready    = drain || ($urandom_range(0, 2) != 0);
            res_ready = drain || ($urandom_range(0, 2) != 0);
            if (!rv_hold) begin
                rvalid = (pend.size() > 0) && (drain || $urandom_range(0, 1) == 1);
                rdata  = (pend.size() > 0) ? alu_f(pend[0]) : '0;
            end
            #1;
            n_cmp++;
            if (outst !== OW'(o_model) || o_model > MAXO) begin
                n_err++; $display("FAIL rand_outst: cycle %0d outst=%0d need %0d", cyc, outst, o_model);
            end
            if (cmd_valid && cmd_ready) host_q.push_back(cmd_data);
            if (wvalid && wready) begin
                n_cmp++;
                if (host_q.size() == 0) begin
                    n_err++; $display("FAIL rand_issue: cycle %0d wdata=%h with no pending command", cyc, wdata);
                end else if (wdata !== host_q[0]) begin
                    n_err++; $display("FAIL rand_issue: cycle %0d wdata=%h need %h", cyc, wdata, host_q[0]);
                end
                if (host_q.size() > 0) void'(host_q.pop_front());
                pend.push_back(wdata);
                o_model++;
            end
            if (res_valid && res_ready) begin
                n_cmp++;
                if (res_exp.size() == 0 || res_data !== res_exp[0]) begin
                    n_err++; $display("FAIL rand_result: cycle %0d res_data=%h need %h", cyc, res_data,
                                      (res_exp.size() > 0) ? res_exp[0] : '0);
                end
                if (res_exp.size() > 0) void'(res_exp.pop_front());
            end
            if (rvalid && rready) begin
                res_exp.push_back(alu_f(pend[0]));
                void'(pend.pop_front());
                o_model--;
                rv_hold = 0;
            end else begin
                rv_hold = rvalid;
            end
            step();
        end
        rvalid = 1'b0; wready = 1'b0; res_ready = 1'b0; cmd_valid = 1'b0;
        n_cmp++;
        if (host_q.size() != 0 || res_exp.size() != 0 || pend.size() != 0 || outst !== '0 || err_unexp !== 1'b0) begin
            n_err++; $display("FAIL rand_drain: cmds=%0d results=%0d alu=%0d outst=%0d err=%b need 0/0/0/0/0",
                              host_q.size(), res_exp.size(), pend.size(), outst, err_unexp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_outst();
        test_fifo_full();
        test_res_backpressure();
        test_flush();
        test_unexp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
